address_register_file: RTL and testbench
========================================

ADDRESS_REGISTER_FILE -- requirements
Module: address_register_file

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; port names are Clock and Reset.
REQ-002 Clock  input  1  rising-edge clock for all register updates.
REQ-003 Reset  input  1  asynchronous active-high reset of all registers.
REQ-004 I  input  16  data input for load/partial-load operations.
REQ-005 RegSel  input  3  active-low register enables: bit2=PC, bit1=AR, bit0=SP; 0 = register updates on the clock edge, 1 = register holds.
REQ-006 FunSel  input  3  operation applied to every enabled register.
REQ-007 OutCSel  input  2  OutC source select.
REQ-008 OutDSel  input  2  OutD source select.
REQ-009 OutC  output  16  selected register value, combinational.
REQ-010 OutD  output  16  selected register value, combinational.

Function
REQ-011 SHALL contain three 16-bit registers, PC, AR and SP, each with its state held in an internal signal named Q, so a bench can reach it hierarchically as PC.Q, AR.Q and SP.Q.
REQ-012 Output select SHALL be decoded identically for OutC and OutD: 00=PC, 01=PC, 10=AR, 11=SP.
REQ-013 OutC/OutD SHALL be purely combinational from register state and select lines, with no clock latency; a select change is visible in the same delta cycle.
REQ-014 The two read ports SHALL be independent; both may select the same register simultaneously.
REQ-015 On each rising Clock edge with Reset low, every register whose RegSel bit is 0 SHALL apply FunSel: 000 Q=Q-1; 001 Q=Q+1; 010 Q=I; 011 Q=0; 100 Q={8'h00,I[7:0]}; 101 Q[7:0]=I[7:0], Q[15:8] unchanged; 110 Q[15:8]=I[7:0], Q[7:0] unchanged; 111 Q={{8{I[7]}},I[7:0]}.
REQ-016 Increment and decrement SHALL be modulo 2^16: FFFF+1=0000 and 0000-1=FFFF, with no flags.
REQ-017 Registers with RegSel bit 1 SHALL hold their value regardless of FunSel or I; RegSel=111 freezes all three registers.
REQ-018 Multiple enabled registers SHALL all perform the same operation on the same edge using the same I.
REQ-019 Register updates SHALL take effect one clock edge after setup; the new value appears on OutC/OutD immediately after that edge.
REQ-020 Register contents written directly by the bench through Q SHALL propagate to the outputs combinationally.

Reset
REQ-021 Reset high SHALL immediately, without waiting for a clock, clear PC, AR and SP to 16'h0000, so OutC and OutD read 16'h0000.
REQ-022 While Reset is high, clock edges SHALL be ignored; operation resumes on the first rising edge after Reset falls.
REQ-023 Reset asserted mid-operation SHALL override any concurrent FunSel/RegSel update.

Verification
REQ-024 Read ports: RegSel=111, PC.Q=1234, SP.Q=5678, OutCSel=00, OutDSel=11, wait 5 time units -> OutC=1234, OutD=5678, with no clock needed.
REQ-025 Selective load: all registers=1234, RegSel=010, FunSel=010, I=3548, one clock, OutCSel=10, OutDSel=01 -> OutC=1234 (AR held), OutD=3548 (PC loaded); SP=3548.
REQ-026 Wrap-around: PC=FFFF, RegSel=011, FunSel=001, one clock -> PC=0000; AR=0000, RegSel=101, FunSel=000, one clock -> AR=FFFF.
REQ-027 Partial loads: SP=ABCD, RegSel=110, I=1280, FunSel=101 -> SP=AB80; FunSel=110 -> 8080; FunSel=111 -> FF80; FunSel=100 -> 0080.
REQ-028 Reset: registers nonzero, assert Reset between clock edges -> all outputs 0000 immediately; a clock edge with RegSel=000, FunSel=001 while Reset is high leaves all registers at 0000.
REQ-029 Hold: RegSel=111, any FunSel/I, several clocks -> all registers unchanged; FunSel=011 with RegSel=000 -> all registers 0000.

Source files
------------

// File: rtl/address_register_file_if.sv
// Register-file bus: operand/control lines driven by the master and the two
// combinational read ports returned by the register file.
//   I       - 16-bit data for load / partial-load operations
//   RegSel  - active-low enables {PC, AR, SP}
//   FunSel  - operation applied to every enabled register
//   OutCSel - OutC source select (00/01=PC, 10=AR, 11=SP)
//   OutDSel - OutD source select (same decode)
//   OutC    - selected register value
//   OutD    - selected register value
interface address_register_file_if;
   logic [15:0] I;
   logic [2:0]  RegSel;
   logic [2:0]  FunSel;
   logic [1:0]  OutCSel;
   logic [1:0]  OutDSel;
   logic [15:0] OutC;
   logic [15:0] OutD;

   modport master (
      output I, RegSel, FunSel, OutCSel, OutDSel,
      input  OutC, OutD
   );

   modport slave (
      input  I, RegSel, FunSel, OutCSel, OutDSel,
      output OutC, OutD
   );
endinterface

// File: rtl/address_register_file.sv
// Address register file: three 16-bit registers (PC, AR, SP) sharing one
// operation code and data input, with two independent combinational read
// ports.
//   Clock - rising-edge clock for all register updates
//   Reset - asynchronous active-high clear of all registers
//   bus   - slave side of address_register_file_if (I, RegSel, FunSel,
//           OutCSel, OutDSel in; OutC, OutD out)

// One 16-bit register; state lives in Q so it can be reached as <inst>.Q.
module addressRegister (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        hold,     // 1 = keep value, 0 = apply funSel
   input  logic [2:0]  funSel,
   input  logic [15:0] din,
   output logic [15:0] q
);
   logic [15:0] Q;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Q <= 16'h0000;
      end else if (!hold) begin
         case (funSel)
            3'b000: Q <= Q - 16'd1;                  // wraps 0000 -> FFFF
            3'b001: Q <= Q + 16'd1;                  // wraps FFFF -> 0000
            3'b010: Q <= din;
            3'b011: Q <= 16'h0000;
            3'b100: Q <= {8'h00, din[7:0]};
            3'b101: Q <= {Q[15:8], din[7:0]};        // low byte only
            3'b110: Q <= {din[7:0], Q[7:0]};         // low byte of I into high byte
            default: Q <= {{8{din[7]}}, din[7:0]};   // sign-extend low byte
         endcase
      end
   end

   assign q = Q;
endmodule

module address_register_file (
   input logic                     Clock,
   input logic                     Reset,
   address_register_file_if.slave  bus
);
   logic [15:0] pcQ, arQ, spQ;

   addressRegister PC (
      .Clock (Clock), .Reset (Reset), .hold (bus.RegSel[2]),
      .funSel(bus.FunSel), .din (bus.I), .q (pcQ)
   );

   addressRegister AR (
      .Clock (Clock), .Reset (Reset), .hold (bus.RegSel[1]),
      .funSel(bus.FunSel), .din (bus.I), .q (arQ)
   );

   addressRegister SP (
      .Clock (Clock), .Reset (Reset), .hold (bus.RegSel[0]),
      .funSel(bus.FunSel), .din (bus.I), .q (spQ)
   );

   // Both read ports share one decode; 00 and 01 both map to PC.
   always_comb begin
      bus.OutC = pcQ;
      case (bus.OutCSel)
         2'b10:   bus.OutC = arQ;
         2'b11:   bus.OutC = spQ;
         default: bus.OutC = pcQ;
      endcase
   end

   always_comb begin
      bus.OutD = pcQ;
      case (bus.OutDSel)
         2'b10:   bus.OutD = arQ;
         2'b11:   bus.OutD = spQ;
         default: bus.OutD = pcQ;
      endcase
   end
endmodule

// File: tb/tb_address_register_file.sv
// Scoreboard bench for address_register_file: stimulus pushes the expected
// OutC/OutD pair and raises obsVld; a separate monitor pops and compares.
module tb_address_register_file;
   logic Clock;
   logic Reset;
   logic obsVld;

   address_register_file_if bus ();

   address_register_file dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus.slave)
   );

   typedef struct {
      string       name;
      logic [15:0] c;
      logic [15:0] d;
   } expT;

   expT sb[$];
   expT monE;
   int  tests  = 0;
   int  failed = 0;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Monitor: compare every presented observation against the queue head.
   always @(posedge obsVld) begin
      tests++;
      if (sb.size() == 0) begin
         failed++;
         $display("FAIL monitor: observation with empty scoreboard, OutC=%h OutD=%h", bus.OutC, bus.OutD);
      end else begin
         monE = sb.pop_front();
         if (bus.OutC !== monE.c || bus.OutD !== monE.d) begin
            failed++;
            $display("FAIL %s: got OutC=%h OutD=%h, expected OutC=%h OutD=%h",
                     monE.name, bus.OutC, bus.OutD, monE.c, monE.d);
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic observe(string n, logic [15:0] c, logic [15:0] d);
      expT e;
      e.name = n;
      e.c    = c;
      e.d    = d;
      sb.push_back(e);
      #1 obsVld = 1'b1;
      #1 obsVld = 1'b0;
   endtask

   task automatic chk(string n, logic [1:0] cs, logic [1:0] ds, logic [15:0] c, logic [15:0] d);
      bus.OutCSel = cs;
      bus.OutDSel = ds;
      observe(n, c, d);
   endtask

   task automatic ld(logic [2:0] rs, logic [2:0] fs, logic [15:0] d);
      bus.RegSel = rs;
      bus.FunSel = fs;
      bus.I      = d;
      tick();
      bus.RegSel = 3'b111;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      obsVld      = 1'b0;
      Reset       = 1'b1;
      bus.I       = 16'h0000;
      bus.RegSel  = 3'b111;
      bus.FunSel  = 3'b000;
      bus.OutCSel = 2'b00;
      bus.OutDSel = 2'b11;
      #2;
      chk("reset_pc_sp", 2'b00, 2'b11, 16'h0000, 16'h0000);
      chk("reset_ar",    2'b10, 2'b01, 16'h0000, 16'h0000);
      @(negedge Clock);
      Reset = 1'b0;

      // Read ports without a clock.
      ld(3'b011, 3'b010, 16'h1234);
      ld(3'b110, 3'b010, 16'h5678);
      bus.OutCSel = 2'b00;
      bus.OutDSel = 2'b11;
      #5;
      observe("read_pc_sp", 16'h1234, 16'h5678);
      chk("read_pc01_ar", 2'b01, 2'b10, 16'h1234, 16'h0000);
      chk("read_same_sp", 2'b11, 2'b11, 16'h5678, 16'h5678);

      // Selective load: AR held, PC and SP loaded.
      ld(3'b000, 3'b010, 16'h1234);
      ld(3'b010, 3'b010, 16'h3548);
      chk("sel_load",    2'b10, 2'b01, 16'h1234, 16'h3548);
      chk("sel_load_sp", 2'b11, 2'b11, 16'h3548, 16'h3548);
      ld(3'b101, 3'b000, 16'hFFFF);
      chk("dec_ar",      2'b10, 2'b00, 16'h1233, 16'h3548);

      // Wrap-around.
      ld(3'b011, 3'b010, 16'hFFFF);
      ld(3'b011, 3'b001, 16'h0000);
      ld(3'b101, 3'b011, 16'h1111);
      ld(3'b101, 3'b000, 16'h0000);
      chk("wrap_pc_ar",   2'b00, 2'b10, 16'h0000, 16'hFFFF);
      chk("wrap_sp_held", 2'b11, 2'b11, 16'h3548, 16'h3548);

      // All three enabled: same op on the same edge.
      ld(3'b000, 3'b001, 16'h0000);
      chk("inc_all_pc_ar", 2'b00, 2'b10, 16'h0001, 16'h0000);
      chk("inc_all_sp",    2'b11, 2'b11, 16'h3549, 16'h3549);

      // Partial loads on SP.
      ld(3'b110, 3'b010, 16'hABCD);
      ld(3'b110, 3'b101, 16'h1280);
      chk("part_low",   2'b00, 2'b11, 16'h0001, 16'hAB80);
      ld(3'b110, 3'b110, 16'h1280);
      chk("part_high",  2'b11, 2'b11, 16'h8080, 16'h8080);
      ld(3'b110, 3'b111, 16'h1280);
      chk("part_sext1", 2'b11, 2'b11, 16'hFF80, 16'hFF80);
      ld(3'b110, 3'b100, 16'h1280);
      chk("part_zext",  2'b11, 2'b11, 16'h0080, 16'h0080);
      ld(3'b110, 3'b111, 16'h347F);
      chk("part_sext0", 2'b11, 2'b11, 16'h007F, 16'h007F);

      // Hold: RegSel=111 ignores FunSel and I.
      ld(3'b101, 3'b010, 16'hBEEF);
      bus.RegSel = 3'b111;
      for (int k = 0; k < 8; k++) begin
         bus.FunSel = k[2:0];
         bus.I      = 16'hC3A5 ^ k[15:0];
         tick();
      end
      chk("hold_pc_sp", 2'b00, 2'b11, 16'h0001, 16'h007F);
      chk("hold_ar",    2'b10, 2'b10, 16'hBEEF, 16'hBEEF);

      // Clear all.
      ld(3'b000, 3'b011, 16'hFFFF);
      chk("clear_pc_ar", 2'b00, 2'b10, 16'h0000, 16'h0000);
      chk("clear_sp",    2'b11, 2'b11, 16'h0000, 16'h0000);

      // Asynchronous reset mid-cycle, clocks ignored while held.
      ld(3'b000, 3'b010, 16'h5A5A);
      chk("pre_reset", 2'b00, 2'b11, 16'h5A5A, 16'h5A5A);
      #1 Reset = 1'b1;
      chk("rst_async_pc_sp", 2'b00, 2'b11, 16'h0000, 16'h0000);
      chk("rst_async_ar",    2'b10, 2'b10, 16'h0000, 16'h0000);
      bus.RegSel = 3'b000;
      bus.FunSel = 3'b001;
      tick();
      chk("rst_clk_pc_sp", 2'b00, 2'b11, 16'h0000, 16'h0000);
      chk("rst_clk_ar",    2'b10, 2'b10, 16'h0000, 16'h0000);
      @(negedge Clock);
      Reset = 1'b0;
      tick();
      bus.RegSel = 3'b111;
      chk("rst_resume", 2'b00, 2'b10, 16'h0001, 16'h0001);

      #5;
      if (sb.size() != 0) begin
         tests++;
         failed++;
         $display("FAIL drain: %0d expected entries never observed, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
